// File: rtl/spwm_pkg.sv
// -----------------------------------------------------------------------------
// spwm_pkg
// Shared constants and types for the sine-PWM gate generator.
//   CNT_W_DEF       carrier counter / sine magnitude width
//   DT_W_DEF        dead-time counter width (must hold DEAD_CYC_DEF)
//   CARRIER_MAX_DEF carrier peak; equals the LUT peak so full scale = 100 %
//   DEAD_CYC_DEF    dead-time length in clock cycles (>= 1)
//   dt_state_t      per-leg dead-time FSM state
// -----------------------------------------------------------------------------
package spwm_pkg;

    localparam int CNT_W_DEF       = 12;
    localparam int DT_W_DEF        = 4;
    localparam int CARRIER_MAX_DEF = 3906;
    localparam int DEAD_CYC_DEF    = 8;

    typedef enum logic [1:0] {
        DT_OFF = 2'd0,
        DT_DT  = 2'd1,
        DT_HI  = 2'd2,
        DT_LO  = 2'd3
    } dt_state_t;

endpackage : spwm_pkg

// File: rtl/spwm_deadtime.sv
// -----------------------------------------------------------------------------
// spwm_deadtime
// One H-bridge leg: turns a PWM demand into complementary high/low gate drives
// with a fixed dead time inserted at every side change.
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_kill  1 = leg forced OFF next cycle (run disabled or fault)
//   i_dem   PWM demand, 1 = high side wanted
//   o_h     high-side gate (registered)
//   o_l     low-side gate (registered)
// -----------------------------------------------------------------------------
module spwm_deadtime
    import spwm_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int DT_W     = DT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_kill,
    input  logic i_dem,
    output logic o_h,
    output logic o_l
);

    localparam logic [DT_W-1:0] DT_ZERO = DT_W'(0);
    localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEAD_CYC - 1);

    dt_state_t       r_state;
    dt_state_t       w_state_nxt;
    logic [DT_W-1:0] r_dt_cnt;
    logic [DT_W-1:0] w_dt_cnt_nxt;
    logic            r_h;
    logic            r_l;

    // Next-state logic; kill overrides every transition.
    always_comb begin
        w_state_nxt  = r_state;
        w_dt_cnt_nxt = r_dt_cnt;
        if (i_kill) begin
            w_state_nxt  = DT_OFF;
            w_dt_cnt_nxt = DT_ZERO;
        end else begin
            case (r_state)
                DT_OFF: begin
                    w_state_nxt  = DT_DT;
                    w_dt_cnt_nxt = DT_ZERO;
                end
                DT_DT: begin
                    // Demand is sampled only at dead-time exit, so a pulse
                    // shorter than the dead time can fall back to the same side.
                    if (r_dt_cnt == DT_LAST) begin
                        w_state_nxt  = i_dem ? DT_HI : DT_LO;
                        w_dt_cnt_nxt = DT_ZERO;
                    end else begin
                        w_state_nxt  = DT_DT;
                        w_dt_cnt_nxt = r_dt_cnt + DT_ONE;
                    end
                end
                DT_HI: begin
                    if (!i_dem) begin
                        w_state_nxt  = DT_DT;
                        w_dt_cnt_nxt = DT_ZERO;
                    end else begin
                        w_state_nxt  = DT_HI;
                        w_dt_cnt_nxt = DT_ZERO;
                    end
                end
                DT_LO: begin
                    if (i_dem) begin
                        w_state_nxt  = DT_DT;
                        w_dt_cnt_nxt = DT_ZERO;
                    end else begin
                        w_state_nxt  = DT_LO;
                        w_dt_cnt_nxt = DT_ZERO;
                    end
                end
                default: begin
                    w_state_nxt  = DT_OFF;
                    w_dt_cnt_nxt = DT_ZERO;
                end
            endcase
        end
    end

    // State, dead-time counter and gate registers; gates are decoded from the
    // next state so they change on the same edge as the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= DT_OFF;
            r_dt_cnt <= DT_ZERO;
            r_h      <= 1'b0;
            r_l      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dt_cnt <= w_dt_cnt_nxt;
            r_h      <= (w_state_nxt == DT_HI);
            r_l      <= (w_state_nxt == DT_LO);
        end
    end

    assign o_h = r_h;
    assign o_l = r_l;

endmodule : spwm_deadtime

// File: rtl/spwm_gate_gen.sv
// -----------------------------------------------------------------------------
// spwm_gate_gen
// Sine-PWM gate generator for a unipolar H-bridge. A symmetric triangle
// carrier is compared against the sine magnitude, regular-sampled at every
// carrier trough; each leg gets complementary gates with dead time.
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_en         run enable (0 = carrier parked at 0, all gates off)
//   i_sine_val   sine magnitude from the LUT
//   i_sine_neg   sine polarity, 1 = negative half-cycle
//   o_samp_tick  1-cycle pulse at the carrier trough while enabled
//   o_gate_ah/al leg A high/low gates
//   o_gate_bh/bl leg B high/low gates
// Optional build macro SPWM_FAULT_EN adds:
//   i_fault      fault input, latches o_fault_lat
//   i_fault_clr  clears the latch when i_fault is low
//   o_fault_lat  latched fault, forces both legs OFF
// -----------------------------------------------------------------------------
module spwm_gate_gen
    import spwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int CARRIER_MAX = CARRIER_MAX_DEF,
    parameter int DEAD_CYC    = DEAD_CYC_DEF,
    parameter int DT_W        = DT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_sine_val,
    input  logic             i_sine_neg,
`ifdef SPWM_FAULT_EN
    input  logic             i_fault,
    input  logic             i_fault_clr,
    output logic             o_fault_lat,
`endif
    output logic             o_samp_tick,
    output logic             o_gate_ah,
    output logic             o_gate_al,
    output logic             o_gate_bh,
    output logic             o_gate_bl
);

    localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(CARRIER_MAX);

    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_down;
    logic [CNT_W-1:0] r_samp_val;
    logic             r_samp_neg;
    logic             r_dem_a;
    logic             r_dem_b;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_trough;
    logic [CNT_W-1:0] w_ref_a;
    logic [CNT_W-1:0] w_ref_b;
    logic             w_fault;
    logic             w_kill;

    assign w_cnt_inc = r_cnt + C_ONE;
    assign w_cnt_dec = r_cnt - C_ONE;
    assign w_trough  = (r_cnt == C_ZERO);

    // Unipolar modulation: only the leg matching the sampled polarity gets a reference.
    assign w_ref_a = r_samp_neg ? C_ZERO : r_samp_val;
    assign w_ref_b = r_samp_neg ? r_samp_val : C_ZERO;

    // Triangle carrier; direction flips on the cycle that reaches the peak or zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= C_ZERO;
            r_dir_down <= 1'b0;
        end else if (!i_en) begin
            r_cnt      <= C_ZERO;
            r_dir_down <= 1'b0;
        end else if (!r_dir_down) begin
            r_cnt      <= w_cnt_inc;
            r_dir_down <= (w_cnt_inc == C_MAX);
        end else begin
            r_cnt      <= w_cnt_dec;
            r_dir_down <= (w_cnt_dec != C_ZERO);
        end
    end

    // Sample-and-hold of the sine magnitude at the carrier trough.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samp_val <= C_ZERO;
            r_samp_neg <= 1'b0;
        end else if (i_en && w_trough) begin
            r_samp_val <= i_sine_val;
            r_samp_neg <= i_sine_neg;
        end else begin
            r_samp_val <= r_samp_val;
            r_samp_neg <= r_samp_neg;
        end
    end

    // Registered compare, strict greater-than so ref 0 never demands high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dem_a <= 1'b0;
            r_dem_b <= 1'b0;
        end else begin
            r_dem_a <= (w_ref_a > r_cnt);
            r_dem_b <= (w_ref_b > r_cnt);
        end
    end

`ifdef SPWM_FAULT_EN
    logic r_fault_lat;

    // Fault latch; a live fault takes priority over the clear request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fault_lat <= 1'b0;
        end else if (i_fault) begin
            r_fault_lat <= 1'b1;
        end else if (i_fault_clr) begin
            r_fault_lat <= 1'b0;
        end else begin
            r_fault_lat <= r_fault_lat;
        end
    end

    assign o_fault_lat = r_fault_lat;
    // The raw fault is included so gates drop on the same edge that sets the latch.
    assign w_fault     = i_fault | r_fault_lat;
`else
    assign w_fault     = 1'b0;
`endif

    assign w_kill = ~i_en | w_fault;

    // The tick is suppressed during reset so every output reads 0 there.
    assign o_samp_tick = ~i_rst & i_en & w_trough;

    spwm_deadtime #(
        .DEAD_CYC (DEAD_CYC),
        .DT_W     (DT_W)
    ) u_leg_a (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_kill (w_kill),
        .i_dem  (r_dem_a),
        .o_h    (o_gate_ah),
        .o_l    (o_gate_al)
    );

    spwm_deadtime #(
        .DEAD_CYC (DEAD_CYC),
        .DT_W     (DT_W)
    ) u_leg_b (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_kill (w_kill),
        .i_dem  (r_dem_b),
        .o_h    (o_gate_bh),
        .o_l    (o_gate_bl)
    );

endmodule : spwm_gate_gen

// File: tb/tb_spwm_gate_gen.sv
// -----------------------------------------------------------------------------
// tb_spwm_gate_gen
// Self-checking bench for spwm_gate_gen (CARRIER_MAX 3906, dead time 8,
// carrier period 7812). Inputs are driven 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spwm_gate_gen;

    localparam int PERIOD = 7812;
    localparam int DEAD   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] sine_val;
    logic        sine_neg;
    logic        samp_tick;
    logic        gate_ah, gate_al, gate_bh, gate_bl;
`ifdef SPWM_FAULT_EN
    logic        fault;
    logic        fault_clr;
    logic        fault_lat;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [11:0] val;
        logic        neg;
        int          ah;
        int          al;
        int          bh;
        int          bl;
        int          ticks;
    } vec_t;

    vec_t tbl [7];
    vec_t sb  [$];

    logic       mon_en = 1'b0;
    int         gap_run  [2];
    logic       gap_seen [2];
    logic [1:0] mon_h;
    logic [1:0] mon_l;

    always #5 clk = ~clk;

    spwm_gate_gen dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_sine_val  (sine_val),
        .i_sine_neg  (sine_neg),
`ifdef SPWM_FAULT_EN
        .i_fault     (fault),
        .i_fault_clr (fault_clr),
        .o_fault_lat (fault_lat),
`endif
        .o_samp_tick (samp_tick),
        .o_gate_ah   (gate_ah),
        .o_gate_al   (gate_al),
        .o_gate_bh   (gate_bh),
        .o_gate_bl   (gate_bl)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    // Counts falling-edge samples with every gate off, starting at the next one.
    task automatic gates_off_run(output int run);
        run = 0;
        @(negedge clk);
        while ({gate_ah, gate_al, gate_bh, gate_bl} == 4'b0000 && run < 50) begin
            run++;
            @(negedge clk);
        end
    endtask

    // Per-leg monitor: never both gates on, and side changes separated by the dead time.
    always @(negedge clk) begin
        mon_h = {gate_bh, gate_ah};
        mon_l = {gate_bl, gate_al};
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "overlap_a" : "overlap_b", int'(mon_h[k] & mon_l[k]), 0);
            if (!mon_en) begin
                gap_run[k]  = 0;
                gap_seen[k] = 1'b0;
            end else if (mon_h[k] | mon_l[k]) begin
                if (gap_seen[k] && gap_run[k] > 0)
                    check(k == 0 ? "deadgap_a" : "deadgap_b", gap_run[k], DEAD);
                gap_seen[k] = 1'b1;
                gap_run[k]  = 0;
            end else begin
                gap_run[k] = gap_run[k] + 1;
            end
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   run;
        int   w;
        int   c_ah, c_al, c_bh, c_bl, c_tick;
        vec_t e;

        // {val, neg, ah, al, bh, bl, ticks} per 7812-cycle window
        tbl[0] = '{12'd1953, 1'b0, 3897, 3899,    0, 7812, 1};
        tbl[1] = '{12'd0,    1'b0,    0, 7812,    0, 7812, 1};
        tbl[2] = '{12'd4000, 1'b1,    0, 7812, 7812,    0, 1};
        tbl[3] = '{12'd3900, 1'b0, 7791,    5,    0, 7812, 1};
        tbl[4] = '{12'd3907, 1'b0, 7812,    0,    0, 7812, 1};
        tbl[5] = '{12'd100,  1'b1,    0, 7812,  191, 7605, 1};
        tbl[6] = '{12'd1,    1'b0,    0, 7804,    0, 7812, 1};

        rst      = 1'b1;
        en       = 1'b1;
        sine_val = 12'd0;
        sine_neg = 1'b0;
`ifdef SPWM_FAULT_EN
        fault     = 1'b0;
        fault_clr = 1'b0;
`endif

        // Reset state, with enable already high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_gates", int'({gate_ah, gate_al, gate_bh, gate_bl}), 0);
        check("reset_tick", int'(samp_tick), 0);
`ifdef SPWM_FAULT_EN
        check("reset_fault_lat", int'(fault_lat), 0);
`endif
        wait_pos();
        en  = 1'b0;
        rst = 1'b0;
        wait_pos();

        // Enable with 1953: tick at once, drop enable at cnt 999 while ah is on
        sine_val = 12'd1953;
        sine_neg = 1'b0;
        en       = 1'b1;
        @(negedge clk);
        check("tick_at_enable", int'(samp_tick), 1);
        repeat (999) @(negedge clk);
        check("ah_before_drop", int'(gate_ah), 1);
        wait_pos();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("gates_after_drop", int'({gate_ah, gate_al, gate_bh, gate_bl}), 0);
        check("tick_while_off", int'(samp_tick), 0);

        // Re-enable: OFF cycle plus dead time before ah comes on
        wait_pos();
        en = 1'b1;
        gates_off_run(run);
        check("reenable_off_run", run, DEAD + 1);
        check("reenable_ah", int'(gate_ah), 1);

        // Sample-and-hold: change to 0 at cnt 100, old value holds until the next trough
        repeat (91) @(negedge clk);
        wait_pos();
        sine_val = 12'd0;
        repeat (900) @(negedge clk);
        check("hold_ah", int'(gate_ah), 1);
        w = 0;
        while (!samp_tick && w < 8000) begin
            @(negedge clk);
            w++;
        end
        check("tick_period", w, PERIOD - 1000);
        repeat (50) @(negedge clk);
        check("hold_update_ah", int'(gate_ah), 0);
        check("hold_update_al", int'(gate_al), 1);

        // Reset in the middle of operation
        wait_pos();
        rst = 1'b1;
        wait_pos();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_gates", int'({gate_ah, gate_al, gate_bh, gate_bl}), 0);
        check("midrst_tick", int'(samp_tick), 1);
        gates_off_run(run);
        check("midrst_off_run", run, DEAD);
        check("midrst_al", int'(gate_al), 1);

`ifdef SPWM_FAULT_EN
        // Fault pulse latches and kills gates; clear ignored while fault is high
        repeat (20) @(negedge clk);
        wait_pos();
        fault = 1'b1;
        wait_pos();
        fault = 1'b0;
        @(negedge clk);
        check("fault_lat_set", int'(fault_lat), 1);
        check("fault_gates", int'({gate_ah, gate_al, gate_bh, gate_bl}), 0);
        wait_pos();
        fault     = 1'b1;
        fault_clr = 1'b1;
        wait_pos();
        fault     = 1'b0;
        fault_clr = 1'b0;
        @(negedge clk);
        check("fault_wins_clr", int'(fault_lat), 1);
        wait_pos();
        fault_clr = 1'b1;
        // latch clears at the next edge, FSM leaves OFF one edge later, then dead time
        gates_off_run(run);
        check("fault_clear_run", run, DEAD + 2);
        check("fault_lat_cleared", int'(fault_lat), 0);
        check("fault_resume_al", int'(gate_al), 1);
        wait_pos();
        fault_clr = 1'b0;
`endif

        // Table-driven steady-state windows through the scoreboard
        for (int i = 0; i < 7; i++) begin
            wait_pos();
            en     = 1'b0;
            mon_en = 1'b0;
            wait_pos();
            sine_val = tbl[i].val;
            sine_neg = tbl[i].neg;
            en       = 1'b1;
            sb.push_back(tbl[i]);
            repeat (30) @(negedge clk);
            mon_en = 1'b1;
            c_ah = 0; c_al = 0; c_bh = 0; c_bl = 0; c_tick = 0;
            for (int c = 0; c < PERIOD; c++) begin
                @(negedge clk);
                c_ah   += int'(gate_ah);
                c_al   += int'(gate_al);
                c_bh   += int'(gate_bh);
                c_bl   += int'(gate_bl);
                c_tick += int'(samp_tick);
            end
            mon_en = 1'b0;
            e = sb.pop_front();
            check($sformatf("v%0d_ah", i), c_ah, e.ah);
            check($sformatf("v%0d_al", i), c_al, e.al);
            check($sformatf("v%0d_bh", i), c_bh, e.bh);
            check($sformatf("v%0d_bl", i), c_bl, e.bl);
            check($sformatf("v%0d_tick", i), c_tick, e.ticks);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spwm_gate_gen
